// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the init/run state enum, the x0 index and the index-width helper.
package reg_file_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int REG0 = 0;

    function automatic int calc_aw(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard with same-cycle writeback masking.
// Ports: clk, rst (sync, active-low), run, wr_hit (registers written this
// cycle), issue_valid/issue_rd (set), flush (clear all), rs -> rs_busy.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [NREGS-1:0]  wr_hit,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rs,
    output logic [NRD-1:0]    rs_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clear on writeback first, then set on issue: the issuing
    // instruction is the younger producer and must win.
    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (issue_valid && issue_rd != AW'(REG0))
            busy_d[issue_rd] = 1'b1;
        if (flush)
            busy_d = '0;
        busy_d[REG0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            busy_q <= '0;
        else if (run)
            busy_q <= busy_d;
    end

    // A register being written this cycle is served by the bypass,
    // so it never reports busy.
    always_comb begin
        rs_busy = '0;
        for (int i = 0; i < NRD; i++)
            rs_busy[i] = run
                       & busy_q[rs[i*AW +: AW]]
                       & ~wr_hit[rs[i*AW +: AW]];
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-through bypass, post-reset
// clear sweep and busy scoreboard. Ports: clk, rst (sync, active-low),
// write_reg/target_reg/write_rd_data (NWR write ports, packed port 0 in
// LSBs), rs/read_data/rs_busy (NRD read ports), issue_valid/issue_rd,
// flush, ready (sweep done).
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NRD     = 2,
    parameter int NWR     = 1,
    parameter int SP_IDX  = 2,
    parameter int SP_INIT = 128,
    localparam int AW     = calc_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      write_reg,
    input  logic [NWR*AW-1:0]   target_reg,
    input  logic [NWR*XLEN-1:0] write_rd_data,
    input  logic [NRD*AW-1:0]   rs,
    output logic [NRD*XLEN-1:0] read_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    input  logic                flush,
    output logic                ready
);

    state_t           state_q;
    logic [AW-1:0]    cnt_q;
    logic             run;
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] wr_hit;

    assign run   = (state_q == ST_RUN);
    assign ready = run;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else if (state_q == ST_INIT) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == AW'(NREGS - 1))
                state_q <= ST_RUN;
        end
    end

    // The array has no reset; the sweep initialises it instead.
    // Ascending port order lets the highest port win on a conflict.
    always_ff @(posedge clk) begin
        if (!run) begin
            regs[cnt_q] <= (cnt_q == AW'(SP_IDX)) ? XLEN'(SP_INIT) : '0;
        end else if (rst) begin
            for (int w = 0; w < NWR; w++)
                if (write_reg[w] && target_reg[w*AW +: AW] != AW'(REG0))
                    regs[target_reg[w*AW +: AW]] <=
                        write_rd_data[w*XLEN +: XLEN];
        end
    end

    always_comb begin
        wr_hit = '0;
        for (int w = 0; w < NWR; w++)
            if (run && write_reg[w])
                wr_hit[target_reg[w*AW +: AW]] = 1'b1;
    end

    always_comb begin
        read_data = '0;
        for (int i = 0; i < NRD; i++) begin
            read_data[i*XLEN +: XLEN] = regs[rs[i*AW +: AW]];
            for (int w = 0; w < NWR; w++)
                if (write_reg[w] &&
                    target_reg[w*AW +: AW] == rs[i*AW +: AW])
                    read_data[i*XLEN +: XLEN] =
                        write_rd_data[w*XLEN +: XLEN];
            if (!run || rs[i*AW +: AW] == AW'(REG0))
                read_data[i*XLEN +: XLEN] = '0;
        end
    end

    reg_file_scoreboard #(
        .NREGS(NREGS),
        .NRD  (NRD),
        .AW   (AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .wr_hit     (wr_hit),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .flush      (flush),
        .rs         (rs),
        .rs_busy    (rs_busy)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (2 read ports, 2 write ports).
// Directed vector table, directed reset sequences and a random phase.
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NWR-1:0]      write_reg;
    logic [NWR*AW-1:0]   target_reg;
    logic [NWR*XLEN-1:0] write_rd_data;
    logic [NRD*AW-1:0]   rs;
    logic [NRD*XLEN-1:0] read_data;
    logic [NRD-1:0]      rs_busy;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                flush;
    logic                ready;

    logic [1:0]  we;
    logic [4:0]  tt [2];
    logic [31:0] dd [2];
    logic [4:0]  rr [2];

    assign write_reg     = we;
    assign target_reg    = {tt[1], tt[0]};
    assign write_rd_data = {dd[1], dd[0]};
    assign rs            = {rr[1], rr[0]};

    always #5 clk = ~clk;

    reg_file_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
        .SP_IDX(2), .SP_INIT(128)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_reg    (write_reg),
        .target_reg   (target_reg),
        .write_rd_data(write_rd_data),
        .rs           (rs),
        .read_data    (read_data),
        .rs_busy      (rs_busy),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .flush        (flush),
        .ready        (ready)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [NREGS];
    bit          m_busy [NREGS];
    bit          m_ready;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  t0, t1;
        logic [31:0] d0, d1;
        logic [4:0]  r0, r1;
        logic        iv;
        logic [4:0]  ird;
        logic        fl;
        logic [31:0] e0, e1;
        logic        eb0, eb1;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t v(
        logic [1:0] we_, logic [4:0] t0, logic [4:0] t1,
        logic [31:0] d0, logic [31:0] d1,
        logic [4:0] r0, logic [4:0] r1,
        logic iv, logic [4:0] ird, logic fl,
        logic [31:0] e0, logic [31:0] e1, logic eb0, logic eb1);
        vec_t x;
        x.we = we_; x.t0 = t0; x.t1 = t1; x.d0 = d0; x.d1 = d1;
        x.r0 = r0; x.r1 = r1; x.iv = iv; x.ird = ird; x.fl = fl;
        x.e0 = e0; x.e1 = e1; x.eb0 = eb0; x.eb1 = eb1;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] we_,
                          input logic [4:0] t0, input logic [4:0] t1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [4:0] r0, input logic [4:0] r1,
                          input logic iv, input logic [4:0] ird,
                          input logic fl);
        we = we_; tt[0] = t0; tt[1] = t1; dd[0] = d0; dd[1] = d1;
        rr[0] = r0; rr[1] = r1;
        issue_valid = iv; issue_rd = ird; flush = fl;
    endtask

    task automatic idle();
        we = 0; tt[0] = 0; tt[1] = 0; dd[0] = 0; dd[1] = 0;
        issue_valid = 0; issue_rd = 0; flush = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = 0;
            m_busy[i] = 0;
        end
        m_regs[2] = 128;
        m_ready   = 0;
    endtask

    function automatic bit m_written(input logic [4:0] r);
        for (int w = 0; w < NWR; w++)
            if (we[w] && tt[w] == r)
                return 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (!m_ready || r == 0)
            return 0;
        for (int w = NWR - 1; w >= 0; w--)
            if (we[w] && tt[w] == r)
                return dd[w];
        return m_regs[r];
    endfunction

    function automatic bit m_rbusy(input logic [4:0] r);
        return m_ready && m_busy[r] && !m_written(r);
    endfunction

    task automatic m_edge();
        if (!m_ready)
            return;
        for (int w = 0; w < NWR; w++)
            if (we[w] && tt[w] != 0)
                m_regs[tt[w]] = dd[w];
        if (flush) begin
            for (int i = 0; i < NREGS; i++)
                m_busy[i] = 0;
        end else begin
            for (int w = 0; w < NWR; w++)
                if (we[w])
                    m_busy[tt[w]] = 0;
            if (issue_valid && issue_rd != 0)
                m_busy[issue_rd] = 1;
        end
        m_busy[0] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_rd0"}, read_data[31:0], m_read(rr[0]));
        chk({tag, "_rd1"}, read_data[63:32], m_read(rr[1]));
        chk({tag, "_bsy"}, rs_busy, {m_rbusy(rr[1]), m_rbusy(rr[0])});
    endtask

    // Entered at posedge+1 of the first cycle with rst high.
    task automatic wait_ready(input string tag);
        int n = 0;
        #4;
        while (!ready && n < 100) begin
            chk({tag, "_init_rd"}, read_data, 64'd0);
            chk({tag, "_init_bsy"}, rs_busy, 2'b00);
            n++;
            @(posedge clk);
            #4;
        end
        chk({tag, "_sweep_len"}, n, 32);
        idle();
        @(posedge clk);
        #1;
        m_ready = ready;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        idle();
        rr[0] = 2;
        rr[1] = 31;
        rst = 0;

        // Power-up reset and sweep
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1'b0);
        chk("rst_rd", read_data, 64'd0);
        chk("rst_bsy", rs_busy, 2'b00);
        rst = 1;
        wait_ready("pwr");
        chk("pwr_ready", ready, 1'b1);
        chk("x2_sp", read_data[31:0], 32'd128);
        chk("x31_zero", read_data[63:32], 32'd0);
        rr[0] = 1;
        rr[1] = 3;
        #1;
        chk("x1_zero", read_data[31:0], 32'd0);
        chk("x3_zero", read_data[63:32], 32'd0);

        // Directed vector table
        tbl.push_back(v(2'b01, 5, 0, 32'hDEADBEEF, 0, 5, 2, 0, 0, 0,
                        32'hDEADBEEF, 128, 0, 0));
        tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 5, 0, 0, 0,
                        0, 32'hDEADBEEF, 0, 0));
        tbl.push_back(v(2'b01, 0, 0, 32'h1234, 0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0));
        tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0,
                        0, 0, 0, 0));
        tbl.push_back(v(2'b11, 7, 7, 1, 2, 7, 5, 0, 0, 0,
                        2, 32'hDEADBEEF, 0, 0));
        tbl.push_back(v(2'b00, 0, 0, 0, 0, 7, 7, 0, 0, 0,
                        2, 2, 0, 0));
        tbl.push_back(v(2'b00, 0, 0, 0, 0, 9, 9, 1, 9, 0,
                        0, 0, 0, 0));
        tbl.push_back(v(2'b00, 0, 0, 0, 0, 9, 5, 0, 0, 0,
                        0, 32'hDEADBEEF, 1, 0));
        tbl.push_back(v(2'b01, 9, 0, 32'hAA, 0, 9, 9, 0, 0, 0,
                        32'hAA, 32'hAA, 0, 0));
        tbl.push_back(v(2'b00, 0, 0, 0, 0, 9, 0, 0, 0, 0,
                        32'hAA, 0, 0, 0));
        tbl.push_back(v(2'b01, 9, 0, 32'hBB, 0, 9, 0, 1, 9, 0,
                        32'hBB, 0, 0, 0));
        tbl.push_back(v(2'b00, 0, 0, 0, 0, 9, 9, 0, 0, 0,
                        32'hBB, 32'hBB, 1, 1));
        tbl.push_back(v(2'b00, 0, 0, 0, 0, 3, 9, 1, 3, 0,
                        0, 32'hBB, 0, 1));
        tbl.push_back(v(2'b00, 0, 0, 0, 0, 3, 4, 1, 4, 0,
                        0, 0, 1, 0));
        tbl.push_back(v(2'b00, 0, 0, 0, 0, 4, 10, 1, 10, 0,
                        0, 0, 1, 0));
        tbl.push_back(v(2'b00, 0, 0, 0, 0, 10, 3, 1, 11, 1,
                        0, 0, 1, 1));
        tbl.push_back(v(2'b00, 0, 0, 0, 0, 10, 11, 0, 0, 0,
                        0, 0, 0, 0));
        tbl.push_back(v(2'b00, 0, 0, 0, 0, 3, 4, 0, 0, 0,
                        0, 0, 0, 0));
        tbl.push_back(v(2'b00, 0, 0, 0, 0, 9, 4, 1, 0, 0,
                        32'hBB, 0, 0, 0));
        tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 2, 0, 0, 0,
                        0, 128, 0, 0));

        foreach (tbl[k]) begin
            set_in(tbl[k].we, tbl[k].t0, tbl[k].t1, tbl[k].d0,
                   tbl[k].d1, tbl[k].r0, tbl[k].r1, tbl[k].iv,
                   tbl[k].ird, tbl[k].fl);
            #4;
            chk($sformatf("vec%0d_rd0", k), read_data[31:0], tbl[k].e0);
            chk($sformatf("vec%0d_rd1", k), read_data[63:32], tbl[k].e1);
            chk($sformatf("vec%0d_bsy", k), rs_busy,
                {tbl[k].eb1, tbl[k].eb0});
            tick();
        end

        // Random traffic against the reference model
        for (int n = 0; n < 500; n++) begin
            set_in(2'($urandom), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), $urandom, $urandom,
                   5'($urandom_range(0, 8)), 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 15) == 0));
            #4;
            chk_model($sformatf("rnd%0d", n));
            tick();
        end

        // Mid-run reset
        idle();
        set_in(2'b01, 5, 0, 7, 0, 12, 5, 1, 12, 0);
        tick();
        idle();
        rr[0] = 12;
        rr[1] = 5;
        #1;
        chk("pre_rst_bsy12", rs_busy[0], 1'b1);
        chk("pre_rst_x5", read_data[63:32], 32'd7);
        rst = 0;
        @(posedge clk);
        #1;
        model_reset();
        chk("mid_rst_ready", ready, 1'b0);
        chk("mid_rst_rd", read_data, 64'd0);
        rst = 1;
        set_in(2'b11, 6, 7, 32'h55, 32'h66, 12, 5, 1, 6, 0);
        wait_ready("mid");
        rr[0] = 5;
        rr[1] = 2;
        #1;
        chk("mid_x5", read_data[31:0], 32'd0);
        chk("mid_x2", read_data[63:32], 32'd128);
        for (int i = 1; i < NREGS; i++) begin
            rr[0] = 5'(i);
            #1;
            chk($sformatf("mid_x%0d", i), read_data[31:0], m_read(rr[0]));
            chk($sformatf("mid_b%0d", i), rs_busy[0], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file with a write-through bypass, a hardware clear sweep after reset, and a per-register busy scoreboard. It replaces the single-write, two-read register file in the decode/writeback path of the pipelined core. Read port count, write port count, width and depth are configurable. The scoreboard lets decode stall on operands whose producer has not yet written back.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 4. AW = $clog2(NREGS).
- NRD, 2, number of read ports.
- NWR, 1, number of write ports.
- SP_IDX, 2, index of the register preloaded at init.
- SP_INIT, 128, value preloaded into register SP_IDX.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- write_reg  in  NWR  per-port write enable.
- target_reg  in  NWR*AW  per-port destination index, packed with port 0 in the LSBs.
- write_rd_data  in  NWR*XLEN  per-port write data, packed.
- rs  in  NRD*AW  per-port read index, packed.
- read_data  out  NRD*XLEN  per-port read data, packed; combinational.
- rs_busy  out  NRD  the register addressed by the port's rs has an outstanding producer; combinational.
- issue_valid  in  1  an instruction with a destination issues this cycle.
- issue_rd  in  AW  destination index of the issuing instruction.
- flush  in  1  clear all busy bits.
- ready  out  1  init sweep complete; register file usable.

## Operation
- FSM states: INIT and RUN.
- **Reset:** rst=0 forces INIT with sweep counter = 0, all busy bits = 0 and ready = 0, regardless of state. The register array is not reset directly.
- **INIT:**
  - Each cycle writes regs[cnt] = (cnt==SP_IDX ? SP_INIT : 0), then increments cnt.
  - After the cycle that writes cnt = NREGS-1, the FSM moves to RUN.
  - In INIT, write_reg, issue_valid and flush are ignored.
  - In INIT, read_data = 0 and rs_busy = 0 on all ports.
- **RUN, writes:**
  - Each enabled port with a nonzero target writes its data at the edge.
  - If several ports target the same register, the highest port index wins.
  - Writes to register 0 are discarded.
- **RUN, reads:**
  - rs = 0 returns 0.
  - Otherwise, if any enabled write port targets rs this cycle, the read returns that port's data (highest index wins). This is the bypass.
  - Otherwise the read returns the array contents.
- **Scoreboard, RUN only:**
  - An enabled write to register r clears busy[r].
  - issue_valid with issue_rd ≠ 0 sets busy[issue_rd].
  - If an issue and a write hit the same register in the same cycle, set wins, because the new producer is younger.
  - issue_rd = 0 is ignored.
  - flush clears every busy bit. When flush and issue_valid are asserted together, flush wins and no bit is set.
  - busy[0] is constant 0.
- rs_busy[i] = busy_q[rs_i] AND NOT (some enabled write targets rs_i this cycle). Data bypassed in the same cycle therefore never reports busy.

## Timing
- Reads, bypass and rs_busy are combinational; zero-cycle latency.
- A write at edge N is visible in the array from cycle N+1 and via the bypass during cycle N.
- An issue in cycle N makes the busy bit visible from cycle N+1.
- Init sweep lasts NREGS cycles after rst returns high. ready rises in the first RUN cycle, i.e. NREGS cycles after the first cycle with rst=1.
- **Reset mid-sweep or mid-run:** the sweep restarts from 0 and ready drops at the next edge.

## Structure
- Shared package reg_file_pkg holds:
  - the FSM state enum (ST_INIT, ST_RUN);
  - the register-0 index constant;
  - a helper computing AW from NREGS.
- One sub-module, reg_file_scoreboard, holds:
  - the NREGS-bit busy vector;
  - set/clear/flush logic;
  - the NRD combinational lookups with same-cycle write masking.
- The top level holds the array, the write-port priority muxing, the bypass and the init FSM.

## Test plan
- **Reset sweep:** hold rst=0 for 3 cycles, then release.
  - ready=0 for exactly 32 cycles, then 1.
  - Reads of x2 = 128; reads of x1 and x31 = 0.
- **Write then read plus bypass:** write x5 = 0xDEADBEEF.
  - rs0 = 5 in the same cycle returns 0xDEADBEEF.
  - rs1 = 5 in the next cycle returns 0xDEADBEEF.
  - Writing x0 = 0x1234 leaves x0 reading 0.
- **Multi-port conflict (NWR=2):** port0 writes x7 = 1 and port1 writes x7 = 2 in the same cycle.
  - The bypass returns 2, and the next-cycle read returns 2.
- **Scoreboard:**
  - Issue rd=9 in cycle N: rs_busy for x9 is 1 from N+1.
  - A writeback of x9 in cycle M gives rs_busy = 0 during M with data bypassed.
  - Issue x9 and write x9 in the same cycle: busy stays 1.
- **Flush:** set busy on x3, x4 and x10, then pulse flush; all rs_busy = 0 next cycle.
- **Mid-run reset:** write x5 = 7, pulse rst low for 1 cycle.
  - ready drops at the next edge; x5 reads 0 during INIT and still reads 0 once ready rises.
  - x2 reads 128 once ready rises; all busy bits are clear.
